// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sched_pkg
//  Description : Shared opcode constants, FSM state type and instruction
//                classification helpers for the issue scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package sched_pkg;

    // Field geometry: every field is one nibble, counted from the MSB.
    localparam int c_FIELD_W    = 4;
    localparam int c_OPC_NIB    = 0;
    localparam int c_DST_NIB    = 1;
    localparam int c_SRCA_NIB   = 2;
    localparam int c_SRCB_NIB   = 3;

    // Control-flow opcodes
    localparam logic [3:0] OP_JMP   = 4'b1000;
    localparam logic [3:0] OP_JMPC  = 4'b1001;
    localparam logic [3:0] OP_MEMPC = 4'b1111;

    typedef enum logic [0:0] {
        RUN           = 1'b0,
        WAIT_REDIRECT = 1'b1
    } sched_state_t;

    // Memory ops live in the 11xx opcode quadrant.
    function automatic logic is_mem(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

    // ALU ops (0xxx) write a register; memory ops write one when op[0] is set.
    function automatic logic is_regwrite(input logic [3:0] op);
        return (~op[3]) | (is_mem(op) & op[0]);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_JMP) | (op == OP_JMPC) | (op == OP_MEMPC);
    endfunction

    // Source operands are meaningful only for ALU and memory ops.
    function automatic logic srcs_checked(input logic [3:0] op);
        return (~op[3]) | is_mem(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : sched_scoreboard
//  Description : Pending-write scoreboard. Holds one bit per register, sets
//                on issue, clears on writeback, and exposes the effective
//                view with the current-cycle writeback already bypassed.
//  Revision    : 1.0 - initial release
// ============================================================================
module sched_scoreboard #(
    parameter int REGS  = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_reg,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_reg,
    output logic [REGS-1:0]  eff
);

    logic [REGS-1:0] r_pend;
    logic [REGS-1:0] w_set_mask;
    logic [REGS-1:0] w_clr_mask;

    // One-hot decode of the set and clear register indices.
    genvar gi;
    generate
        for (gi = 0; gi < REGS; gi++) begin : g_mask
            assign w_set_mask[gi] = set_en & (set_reg == IDX_W'(gi));
            assign w_clr_mask[gi] = clr_en & (clr_reg == IDX_W'(gi));
        end
    endgenerate

    // A writeback in this cycle is already visible to the hazard check.
    assign eff = r_pend & ~w_clr_mask;

    // Set is applied after clear so an issue to the written-back register wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= eff | w_set_mask;
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler
//  Description : In-order single-entry issue stage between fetch and decode.
//                Stalls on RAW/WAW/memory-port hazards and holds fetch after
//                control-flow ops until the PC redirect is confirmed.
//                Optional performance counters: ISSUE_SCHED_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int N     = 24,
    parameter int REGS  = 16
`ifdef ISSUE_SCHED_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_instr,
    input  logic             out_ready,
    input  logic             wb_valid,
    input  logic [3:0]       wb_reg,
    input  logic             mem_done,
    input  logic             redirect_valid,
    output logic             fetch_hold
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int c_OPC_HI  = N - 1 - c_OPC_NIB  * c_FIELD_W;
    localparam int c_DST_HI  = N - 1 - c_DST_NIB  * c_FIELD_W;
    localparam int c_SRCA_HI = N - 1 - c_SRCA_NIB * c_FIELD_W;
    localparam int c_SRCB_HI = N - 1 - c_SRCB_NIB * c_FIELD_W;

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic            r_out_valid;
    logic [N-1:0]    r_out_instr;
    logic            r_mem_busy;

    logic [3:0]      w_opc;
    logic [3:0]      w_dst;
    logic [3:0]      w_src_a;
    logic [3:0]      w_src_b;
    logic            w_is_wr;
    logic            w_is_mem;
    logic            w_is_ctrl;
    logic [REGS-1:0] w_eff;
    logic            w_hazard;
    logic            w_run;
    logic            w_issue;

    assign w_opc     = in_instr[c_OPC_HI  -: c_FIELD_W];
    assign w_dst     = in_instr[c_DST_HI  -: c_FIELD_W];
    assign w_src_a   = in_instr[c_SRCA_HI -: c_FIELD_W];
    assign w_src_b   = in_instr[c_SRCB_HI -: c_FIELD_W];
    assign w_is_wr   = is_regwrite(w_opc);
    assign w_is_mem  = is_mem(w_opc);
    assign w_is_ctrl = is_ctrl(w_opc);

    sched_scoreboard #(
        .REGS  (REGS),
        .IDX_W (4)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (w_issue & w_is_wr),
        .set_reg (w_dst),
        .clr_en  (wb_valid),
        .clr_reg (wb_reg),
        .eff     (w_eff)
    );

    // A finishing memory op frees the port in the same cycle.
    assign w_hazard = (srcs_checked(w_opc) & (w_eff[w_src_a] | w_eff[w_src_b]))
                    | (w_is_wr & w_eff[w_dst])
                    | (w_is_mem & r_mem_busy & ~mem_done);

    assign in_ready  = w_run & ~w_hazard & (~r_out_valid | out_ready);
    assign w_issue   = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: control ops park us until fetch confirms the redirect.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        fetch_hold  = 1'b0;
        case (r_state)
            RUN: begin
                w_run = 1'b1;
                if (w_issue && w_is_ctrl) begin
                    w_state_nxt = WAIT_REDIRECT;
                end
            end
            WAIT_REDIRECT: begin
                fetch_hold = 1'b1;
                if (redirect_valid) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Output register: load on issue, drop once the decoder consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_instr <= in_instr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Single memory port: a new memory issue keeps it busy over a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_busy <= 1'b0;
        end else if (w_issue && w_is_mem) begin
            r_mem_busy <= 1'b1;
        end else if (mem_done) begin
            r_mem_busy <= 1'b0;
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters for hazard stalls and redirect wait cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_run && in_valid && !in_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (fetch_hold && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_scheduler
//  Description : Directed self-checking bench for issue_scheduler. Stimulus
//                pushes each expected-accepted instruction into a queue; a
//                monitor compares out_instr against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

    localparam int N = 24;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [N-1:0]  in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_instr;
    logic          out_ready;
    logic          wb_valid;
    logic [3:0]    wb_reg;
    logic          mem_done;
    logic          redirect_valid;
    logic          fetch_hold;
`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
    int            exp_stall;
    int            exp_flush;
`endif

    int            n_checks;
    int            n_fail;
    logic [N-1:0]  exp_q[$];

    issue_scheduler #(
        .N    (N),
        .REGS (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .mem_done       (mem_done),
        .redirect_valid (redirect_valid),
        .fetch_hold     (fetch_hold)
`ifdef ISSUE_SCHED_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check handshake outputs, record acceptances.
    task automatic step(input logic v, input logic [N-1:0] ins, input logic ordy,
                        input logic wbv, input logic [3:0] wbr, input logic md,
                        input logic rv, input logic exp_rdy, input logic exp_hold);
        in_valid       = v;
        in_instr       = ins;
        out_ready      = ordy;
        wb_valid       = wbv;
        wb_reg         = wbr;
        mem_done       = md;
        redirect_valid = rv;
        @(negedge clk);
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("fetch_hold", {31'd0, fetch_hold}, {31'd0, exp_hold});
        if (v && exp_rdy) exp_q.push_back(ins);
`ifdef ISSUE_SCHED_PERF_EN
        if (v && !exp_rdy && !exp_hold) exp_stall++;
        if (exp_hold) exp_flush++;
`endif
        @(posedge clk);
        #1;
    endtask

    // Monitor: any valid output must match the oldest outstanding issue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got 0x%0h, expected no output at %0t", out_instr, $time);
            end else begin
                chk("out_instr", {8'd0, out_instr}, {8'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
`ifdef ISSUE_SCHED_PERF_EN
        exp_stall      = 0;
        exp_flush      = 0;
`endif
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_instr       = '0;
        out_ready      = 1'b1;
        wb_valid       = 1'b0;
        wb_reg         = 4'd0;
        mem_done       = 1'b0;
        redirect_valid = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", {8'd0, out_instr}, 32'd0);
        chk("rst_fetch_hold", {31'd0, fetch_hold}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ISSUE_SCHED_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        rst_n = 1'b1;

        // Back-to-back independent ALU ops
        step(1, 24'h110000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(1, 24'h220000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd1, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd2, 0, 0, 1, 0);

        // RAW on r3, released by same-cycle writeback
        step(1, 24'h130000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(1, 24'h243000, 1, 0, 4'd0, 0, 0, 0, 0);
        step(1, 24'h243000, 1, 0, 4'd0, 0, 0, 0, 0);
        step(1, 24'h243000, 1, 1, 4'd3, 0, 0, 1, 0);

        // Writeback to non-pending r5 alongside an issue setting r5: set wins
        step(1, 24'h150000, 1, 1, 4'd5, 0, 0, 1, 0);
        step(1, 24'h250000, 1, 0, 4'd0, 0, 0, 0, 0);
        step(1, 24'h250000, 1, 1, 4'd5, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd4, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd5, 0, 0, 1, 0);

        // Memory serialization
        step(1, 24'hD50000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(1, 24'hC00000, 1, 0, 4'd0, 0, 0, 0, 0);
        step(1, 24'hC00000, 1, 0, 4'd0, 0, 0, 0, 0);
        step(1, 24'hC00000, 1, 0, 4'd0, 1, 0, 1, 0);
        step(1, 24'hC00000, 1, 0, 4'd0, 0, 0, 0, 0);
        step(0, 24'h000000, 1, 0, 4'd0, 1, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd5, 0, 0, 1, 0);

        // Redirect in RUN is ignored
        step(0, 24'h000000, 1, 0, 4'd0, 0, 1, 1, 0);
        step(0, 24'h000000, 1, 0, 4'd0, 0, 0, 1, 0);

        // Jump: three wait cycles, the last one sampling redirect_valid
        step(1, 24'h800010, 1, 0, 4'd0, 0, 0, 1, 0);
        step(1, 24'h110000, 1, 0, 4'd0, 0, 0, 0, 1);
        step(1, 24'h110000, 1, 0, 4'd0, 0, 0, 0, 1);
        step(1, 24'h110000, 1, 0, 4'd0, 0, 1, 0, 1);
        step(1, 24'h110000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd1, 0, 0, 1, 0);
`ifdef ISSUE_SCHED_PERF_EN
        chk("flush_cnt_jump", flush_cnt, 32'd3);
`endif

        // Decoder backpressure for four cycles
        step(1, 24'h160000, 0, 0, 4'd0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 24'h270000, 0, 0, 4'd0, 0, 0, 0, 0);
        end
        step(1, 24'h270000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd6, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 1, 4'd7, 0, 0, 1, 0);

`ifdef ISSUE_SCHED_PERF_EN
        chk("stall_cnt", stall_cnt, 32'(exp_stall));
        chk("flush_cnt", flush_cnt, 32'(exp_flush));
`endif

        // Asynchronous reset with r7 pending and in WAIT_REDIRECT
        step(1, 24'h170000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(1, 24'h900000, 1, 0, 4'd0, 0, 0, 1, 0);
        in_valid = 1'b0;
        in_instr = 24'h170000;
        #1;
        chk("pre_rst_fetch_hold", {31'd0, fetch_hold}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_instr", {8'd0, out_instr}, 32'd0);
        chk("arst_fetch_hold", {31'd0, fetch_hold}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 24'h170000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 0, 4'd0, 0, 0, 1, 0);
        step(0, 24'h000000, 1, 0, 4'd0, 0, 0, 1, 0);

        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
